// File: rtl/mem_stage_unit.sv
// MEM stage of the 5-stage MIPS pipeline: data memory, branch resolution and the MEM/WB register.
// Define MEM_BYTE_HALF_EN to enable byte/halfword loads and stores (sb/sh/lb/lbu/lh/lhu).
module mem_stage_unit #(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Zero_in,
  input  logic [31:0] ALUAddResult_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] WriteData_in,
  input  logic [4:0]  WriteReg_in,
  input  logic [1:0]  MemSize_in,
  input  logic        MemSigned_in,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUResult_out,
  output logic [4:0]  WriteReg_out,
  output logic        MisalignErr
);
  localparam int         DATA_W  = 32;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [DATA_W-1:0] mem_q [0:MEM_WORDS-1];

  logic [ADDR_W-1:0] idx_p0;
  logic [1:0]        lane_p0;
  logic [1:0]        size_p0;
  logic              sgn_p0;
  logic              mem_op_p0;
  logic              misaligned_p0;
  logic              mem_we_p0;
  logic [3:0]        be_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] rd_word_p0;

  logic              regwrite_p1_d, regwrite_p1_q;
  logic              memtoreg_p1_d, memtoreg_p1_q;
  logic [DATA_W-1:0] rdata_p1_d,    rdata_p1_q;
  logic [DATA_W-1:0] alu_p1_d,      alu_p1_q;
  logic [4:0]        wreg_p1_d,     wreg_p1_q;
  logic              err_d,         err_q;

  // Sub-word load: pick the lane little-endian and extend by sign or zero.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                     input logic [1:0] lane,
                                                     input logic [1:0] size,
                                                     input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_extract = {{24{sgn & b[7]}}, b};
      SZ_HALF: load_extract = {{16{sgn & h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_enables = 4'b0001 << lane;
      SZ_HALF: lane_enables = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_lanes(input logic [1:0] size, input logic [DATA_W-1:0] data);
    case (size)
      SZ_BYTE: store_lanes = {4{data[7:0]}};
      SZ_HALF: store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

`ifdef MEM_BYTE_HALF_EN
  assign size_p0 = (MemSize_in == 2'b11) ? SZ_WORD : MemSize_in;
  assign sgn_p0  = MemSigned_in;
`else
  logic unused_size_sign;
  assign size_p0          = SZ_WORD;
  assign sgn_p0           = 1'b0;
  assign unused_size_sign = ^{MemSize_in, MemSigned_in};
`endif

  // Stage p0: instruction sitting in MEM, decoded from the EX/MEM latch
  assign PCSrc        = Branch_in & Zero_in & ~Flush;
  assign BranchTarget = ALUAddResult_in;

  assign idx_p0        = ALUResult_in[ADDR_W+1:2];
  assign lane_p0       = ALUResult_in[1:0];
  assign mem_op_p0     = MemRead_in | MemWrite_in;
  assign misaligned_p0 = mem_op_p0 &
                         (((size_p0 == SZ_WORD) & (lane_p0 != 2'b00)) |
                          ((size_p0 == SZ_HALF) & lane_p0[0]));
  assign mem_we_p0     = MemWrite_in & ~Stall & ~Flush & ~misaligned_p0 & ~Reset;
  assign be_p0         = lane_enables(size_p0, lane_p0);
  assign wdata_p0      = store_lanes(size_p0, WriteData_in);
  assign rd_word_p0    = mem_q[idx_p0];

  always_ff @(posedge Clk) begin
    if (mem_we_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (be_p0[i]) mem_q[idx_p0][8*i +: 8] <= wdata_p0[8*i +: 8];
      end
    end
  end

  always_comb begin
    regwrite_p1_d = regwrite_p1_q;
    memtoreg_p1_d = memtoreg_p1_q;
    rdata_p1_d    = rdata_p1_q;
    alu_p1_d      = alu_p1_q;
    wreg_p1_d     = wreg_p1_q;
    err_d         = err_q;
    if (!Stall) begin
      if (Flush) begin
        regwrite_p1_d = 1'b0;
        memtoreg_p1_d = 1'b0;
        rdata_p1_d    = '0;
        alu_p1_d      = '0;
        wreg_p1_d     = '0;
      end else begin
        regwrite_p1_d = RegWrite_in;
        memtoreg_p1_d = MemtoReg_in;
        rdata_p1_d    = (MemRead_in & ~misaligned_p0) ?
                        load_extract(rd_word_p0, lane_p0, size_p0, sgn_p0) : '0;
        alu_p1_d      = ALUResult_in;
        wreg_p1_d     = WriteReg_in;
        err_d         = err_q | misaligned_p0;
      end
    end
  end

  // Stage p1: MEM/WB register feeding write-back
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      regwrite_p1_q <= 1'b0;
      memtoreg_p1_q <= 1'b0;
      rdata_p1_q    <= '0;
      alu_p1_q      <= '0;
      wreg_p1_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      regwrite_p1_q <= regwrite_p1_d;
      memtoreg_p1_q <= memtoreg_p1_d;
      rdata_p1_q    <= rdata_p1_d;
      alu_p1_q      <= alu_p1_d;
      wreg_p1_q     <= wreg_p1_d;
      err_q         <= err_d;
    end
  end

  assign RegWrite_out  = regwrite_p1_q;
  assign MemtoReg_out  = memtoreg_p1_q;
  assign ReadData_out  = rdata_p1_q;
  assign ALUResult_out = alu_p1_q;
  assign WriteReg_out  = wreg_p1_q;
  assign MisalignErr   = err_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: directed vectors plus randomized traffic against a reference model.
module tb_mem_stage_unit;
  logic        Clk, Reset, Stall, Flush;
  logic        RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Zero_in;
  logic [31:0] ALUAddResult_in, ALUResult_in, WriteData_in;
  logic [4:0]  WriteReg_in;
  logic [1:0]  MemSize_in;
  logic        MemSigned_in;
  logic        PCSrc, RegWrite_out, MemtoReg_out, MisalignErr;
  logic [31:0] BranchTarget, ReadData_out, ALUResult_out;
  logic [4:0]  WriteReg_out;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] mref [0:1023];
  logic        e_rw, e_mtr, e_err;
  logic [31:0] e_rd, e_alu;
  logic [4:0]  e_wr;

  mem_stage_unit dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Zero_in(Zero_in),
    .ALUAddResult_in(ALUAddResult_in), .ALUResult_in(ALUResult_in),
    .WriteData_in(WriteData_in), .WriteReg_in(WriteReg_in),
    .MemSize_in(MemSize_in), .MemSigned_in(MemSigned_in),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .RegWrite_out(RegWrite_out),
    .MemtoReg_out(MemtoReg_out), .ReadData_out(ReadData_out),
    .ALUResult_out(ALUResult_out), .WriteReg_out(WriteReg_out),
    .MisalignErr(MisalignErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        branch, zero, flush, stall;
    logic [31:0] target;
    logic        exp_pcsrc;
  } br_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    Stall = 0; Flush = 0; RegWrite_in = 0; MemtoReg_in = 0; Branch_in = 0;
    MemRead_in = 0; MemWrite_in = 0; Zero_in = 0; ALUAddResult_in = 0;
    ALUResult_in = 0; WriteData_in = 0; WriteReg_in = 0;
    MemSize_in = 2'b10; MemSigned_in = 0;
  endtask

  task automatic model_reset();
    e_rw = 0; e_mtr = 0; e_err = 0; e_rd = 0; e_alu = 0; e_wr = 0;
  endtask

  function automatic int acc_size();
`ifdef MEM_BYTE_HALF_EN
    if (MemSize_in == 2'b00) return 0;
    if (MemSize_in == 2'b01) return 1;
`endif
    return 2;
  endfunction

  // One clock of the stage, evaluated from the behavioural rules on the current inputs.
  task automatic model_step();
    int a, idx, sz, sh;
    logic [31:0] w, v, m;
    bit mis;
    if (Reset) begin model_reset(); return; end
    if (Stall) return;
    if (Flush) begin
      e_rw = 0; e_mtr = 0; e_rd = 0; e_alu = 0; e_wr = 0;
      return;
    end
    sz  = acc_size();
    a   = int'(ALUResult_in & 32'hFFF);
    idx = a / 4;
    sh  = 8 * (a % 4);
    mis = (MemRead_in || MemWrite_in) && ((sz == 2 && a % 4 != 0) || (sz == 1 && a % 2 != 0));
    w   = mref[idx];
    if (!MemRead_in || mis) v = 0;
    else if (sz == 2) v = w;
    else if (sz == 1) begin
      v = (w >> sh) & 32'hFFFF;
      if (MemSigned_in && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = (w >> sh) & 32'hFF;
      if (MemSigned_in && v[7]) v = v | 32'hFFFFFF00;
    end
    e_rw = RegWrite_in; e_mtr = MemtoReg_in; e_rd = v; e_alu = ALUResult_in; e_wr = WriteReg_in;
    if (MemWrite_in && !mis) begin
      if (sz == 2) mref[idx] = WriteData_in;
      else begin
        m = (sz == 1) ? (32'hFFFF << sh) : (32'hFF << sh);
        mref[idx] = (w & ~m) | ((WriteData_in << sh) & m);
      end
    end
    if (mis) e_err = 1;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".RegWrite_out"}, {31'b0, RegWrite_out}, {31'b0, e_rw});
    chk({tag, ".MemtoReg_out"}, {31'b0, MemtoReg_out}, {31'b0, e_mtr});
    chk({tag, ".ReadData_out"}, ReadData_out, e_rd);
    chk({tag, ".ALUResult_out"}, ALUResult_out, e_alu);
    chk({tag, ".WriteReg_out"}, {27'b0, WriteReg_out}, {27'b0, e_wr});
    chk({tag, ".MisalignErr"}, {31'b0, MisalignErr}, {31'b0, e_err});
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge Clk);
    #1;
    check_outs(tag);
  endtask

  br_vec_t tbl[6];

  initial begin
    tbl[0] = '{1, 1, 0, 0, 32'h0000_0040, 1};
    tbl[1] = '{1, 1, 1, 0, 32'h0000_0040, 0};
    tbl[2] = '{1, 0, 0, 0, 32'h0000_0080, 0};
    tbl[3] = '{0, 1, 0, 0, 32'h0000_0084, 0};
    tbl[4] = '{1, 1, 0, 1, 32'hFFFF_FFFC, 1};
    tbl[5] = '{1, 1, 1, 1, 32'h0000_0010, 0};

    set_idle();
    Reset = 0;
    model_reset();
    #2 Reset = 1;
    #2;
    check_outs("reset_init");
    @(posedge Clk); #3 Reset = 0;

    // preload the low 64 words so every later load reads defined data
    for (int i = 0; i < 64; i++) begin
      set_idle();
      MemWrite_in = 1; ALUResult_in = i * 4; WriteData_in = $urandom;
      tick("fill");
    end

    // sw / lw round trip
    set_idle();
    MemWrite_in = 1; ALUResult_in = 32'h10; WriteData_in = 32'hDEADBEEF;
    tick("sw10");
    set_idle();
    MemRead_in = 1; MemtoReg_in = 1; RegWrite_in = 1; ALUResult_in = 32'h10; WriteReg_in = 5'd8;
    tick("lw10");
    chk("lw10_data", ReadData_out, 32'hDEADBEEF);
    chk("lw10_memtoreg", {31'b0, MemtoReg_out}, 32'd1);

    // branch resolution table
    for (int i = 0; i < 6; i++) begin
      set_idle();
      Branch_in = tbl[i].branch; Zero_in = tbl[i].zero; Flush = tbl[i].flush;
      Stall = tbl[i].stall; ALUAddResult_in = tbl[i].target;
      #1;
      chk($sformatf("br%0d_pcsrc", i), {31'b0, PCSrc}, {31'b0, tbl[i].exp_pcsrc});
      chk($sformatf("br%0d_target", i), BranchTarget, tbl[i].target);
      tick($sformatf("br%0d", i));
    end

    // stalled store: outputs hold, the write lands on the release cycle only
    set_idle();
    RegWrite_in = 1; ALUResult_in = 32'h77; WriteReg_in = 5'd3;
    tick("pre_stall");
    set_idle();
    MemWrite_in = 1; ALUResult_in = 32'h20; WriteData_in = 32'h1234; Stall = 1;
    tick("stall1");
    chk("stall1_alu_held", ALUResult_out, 32'h77);
    tick("stall2");
    chk("stall2_alu_held", ALUResult_out, 32'h77);
    chk("stall2_rw_held", {31'b0, RegWrite_out}, 32'd1);
    Stall = 0;
    tick("stall_release");
    chk("release_alu", ALUResult_out, 32'h20);
    set_idle();
    MemRead_in = 1; MemtoReg_in = 1; RegWrite_in = 1; ALUResult_in = 32'h20;
    tick("lw20");
    chk("lw20_data", ReadData_out, 32'h1234);

    // misaligned word store and load
    chk("err_before_mis", {31'b0, MisalignErr}, 32'd0);
    set_idle();
    MemWrite_in = 1; ALUResult_in = 32'h22; WriteData_in = 32'h5555;
    tick("sw22_mis");
    chk("mis_err_set", {31'b0, MisalignErr}, 32'd1);
    set_idle();
    MemRead_in = 1; RegWrite_in = 1; ALUResult_in = 32'h20;
    tick("lw20_after_mis");
    chk("lw20_prior", ReadData_out, 32'h1234);
    chk("mis_err_sticky", {31'b0, MisalignErr}, 32'd1);
    set_idle();
    MemRead_in = 1; RegWrite_in = 1; ALUResult_in = 32'h22; WriteReg_in = 5'd9;
    tick("lw22_mis");
    chk("lw22_zero", ReadData_out, 32'h0);
    chk("lw22_rw", {31'b0, RegWrite_out}, 32'd1);

    // reset mid-cycle during a pending store
    set_idle();
    MemWrite_in = 1; ALUResult_in = 32'h20; WriteData_in = 32'hCAFEF00D; RegWrite_in = 1;
    #2 Reset = 1;
    model_reset();
    #1;
    check_outs("mid_reset");
    chk("mid_reset_err", {31'b0, MisalignErr}, 32'd0);
    tick("reset_held");
    #2 Reset = 0;
    set_idle();
    MemRead_in = 1; ALUResult_in = 32'h20;
    tick("lw20_after_reset");
    chk("store_dropped", ReadData_out, 32'h1234);

    // randomized traffic; upper address bits exercise wrap-around
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [31:0] r;
      set_idle();
      op = int'($urandom_range(0, 3));
      r  = $urandom;
      ALUResult_in = {r[31:12], 4'b0000, r[7:0]};
      if ($urandom_range(0, 3) != 0) ALUResult_in[1:0] = 2'b00;
      WriteData_in = $urandom; WriteReg_in = 5'($urandom);
      ALUAddResult_in = $urandom; Zero_in = 1'($urandom);
      MemSize_in = 2'($urandom); MemSigned_in = 1'($urandom);
      case (op)
        0: RegWrite_in = 1;
        1: begin MemRead_in = 1; MemtoReg_in = 1; RegWrite_in = 1; end
        2: MemWrite_in = 1;
        default: Branch_in = 1;
      endcase
      Stall = ($urandom_range(0, 4) == 0);
      Flush = ($urandom_range(0, 6) == 0);
      #1;
      chk("rnd_pcsrc", {31'b0, PCSrc}, {31'b0, Branch_in & Zero_in & ~Flush});
      chk("rnd_target", BranchTarget, ALUAddResult_in);
      tick("rnd");
    end

`ifdef MEM_BYTE_HALF_EN
    set_idle();
    MemWrite_in = 1; ALUResult_in = 32'h30; WriteData_in = 32'h11223344;
    tick("sw30");
    set_idle();
    MemWrite_in = 1; MemSize_in = 2'b00; ALUResult_in = 32'h31; WriteData_in = 32'h9876_54AA;
    tick("sb31");
    set_idle();
    MemRead_in = 1; ALUResult_in = 32'h30;
    tick("lw30");
    chk("lw30_merged", ReadData_out, 32'h1122AA44);
    set_idle();
    MemRead_in = 1; MemSize_in = 2'b00; MemSigned_in = 1; ALUResult_in = 32'h31;
    tick("lb31");
    chk("lb31", ReadData_out, 32'hFFFFFFAA);
    MemSigned_in = 0;
    tick("lbu31");
    chk("lbu31", ReadData_out, 32'h000000AA);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
